// File: rtl/clip_obj_store.sv
// Object point store behind the clipper refresh interface: the host writes/deletes 4-point objects, the sequencer reads one point per strobe.
// Optional build macro CLIP_STORE_PARITY_EN adds a per-point even-parity bit and a sticky par_err output.
module clip_obj_store #(
    parameter int NUM_OBJ = 32,
    parameter int ADDR_W  = 5,
    parameter int PT_W    = 48
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               wr_req,
    input  logic               wr_del,
    input  logic [ADDR_W-1:0]  wr_obj,
    input  logic               wr_vld,
    input  logic [PT_W-1:0]    wr_pt,
    output logic               wr_rdy,
    output logic               wr_done,
    input  logic               rd_en,
    input  logic [ADDR_W-1:0]  rd_addr,
    input  logic [3:0]         rd_cycle,
    input  logic               clr_changed,
    output logic [PT_W-1:0]    rd_pt,
    output logic               rd_pt_vld,
    output logic [NUM_OBJ-1:0] obj_map,
    output logic               changed,
`ifdef CLIP_STORE_PARITY_EN
    output logic               writing,
    output logic               par_err
`else
    output logic               writing
`endif
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_BEAT   = 2'd1;
    localparam logic [1:0] ST_COMMIT = 2'd2;

`ifdef CLIP_STORE_PARITY_EN
    localparam int MEM_W = PT_W + 1;
`else
    localparam int MEM_W = PT_W;
`endif

    // Even parity: the stored bit makes the total number of ones even.
    function automatic logic even_par(input logic [PT_W-1:0] d);
        return ^d;
    endfunction

    // Returns {valid, index}; anything other than exactly one hot bit is invalid.
    function automatic logic [2:0] onehot2idx(input logic [3:0] c);
        logic [2:0] r;
        case (c)
            4'b0001: r = 3'b100;
            4'b0010: r = 3'b101;
            4'b0100: r = 3'b110;
            4'b1000: r = 3'b111;
            default: r = 3'b000;
        endcase
        return r;
    endfunction

    logic [1:0]         state_r;
    logic [1:0]         state_nxt_s;
    logic [1:0]         beat_cnt_r;
    logic [ADDR_W-1:0]  obj_r;
    logic [MEM_W-1:0]   shadow_r [0:3];
    logic [MEM_W-1:0]   mem_r    [0:NUM_OBJ-1][0:3];
    logic [NUM_OBJ-1:0] obj_map_r;
    logic               wr_rdy_r;
    logic               wr_done_r;
    logic               writing_r;
    logic               changed_r;
    logic [PT_W-1:0]    rd_pt_r;
    logic               rd_pt_vld_r;
    logic               del_s;
    logic               start_s;
    logic               beat_s;
    logic               commit_s;
    logic [MEM_W-1:0]   wr_word_s;
    logic [MEM_W-1:0]   rd_word_s;
    logic [2:0]         rd_sel_s;
    logic               rd_ok_s;

`ifdef CLIP_STORE_PARITY_EN
    logic rd_par_r;
    logic par_err_r;
    assign wr_word_s = {even_par(wr_pt), wr_pt};
    assign par_err   = par_err_r;
`else
    assign wr_word_s = wr_pt;
`endif

    assign wr_rdy    = wr_rdy_r;
    assign wr_done   = wr_done_r;
    assign writing   = writing_r;
    assign changed   = changed_r;
    assign obj_map   = obj_map_r;
    assign rd_pt     = rd_pt_r;
    assign rd_pt_vld = rd_pt_vld_r;

    // Host-side transaction decode and next state.
    always_comb begin
        state_nxt_s = state_r;
        del_s       = 1'b0;
        start_s     = 1'b0;
        beat_s      = 1'b0;
        commit_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (wr_rdy_r && wr_req) begin
                    if (wr_del) begin
                        del_s = 1'b1;
                    end else begin
                        start_s     = 1'b1;
                        state_nxt_s = ST_BEAT;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_BEAT: begin
                if (wr_vld) begin
                    beat_s = 1'b1;
                    if (beat_cnt_r == 2'd3) begin
                        state_nxt_s = ST_COMMIT;
                    end else begin
                        state_nxt_s = ST_BEAT;
                    end
                end else begin
                    state_nxt_s = ST_BEAT;
                end
            end
            ST_COMMIT: begin
                commit_s    = 1'b1;
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // FSM, shadow capture, slot bitmap and host-visible status flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            beat_cnt_r <= 2'd0;
            obj_r      <= '0;
            obj_map_r  <= '0;
            wr_rdy_r   <= 1'b0;
            wr_done_r  <= 1'b0;
            writing_r  <= 1'b0;
            changed_r  <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                shadow_r[i] <= '0;
            end
        end else begin
            state_r   <= state_nxt_s;
            wr_rdy_r  <= (state_nxt_s != ST_COMMIT);
            wr_done_r <= del_s | commit_s;
            writing_r <= (state_nxt_s != ST_IDLE) | del_s;
            if (start_s) begin
                obj_r      <= wr_obj;
                beat_cnt_r <= 2'd0;
            end else if (beat_s) begin
                shadow_r[beat_cnt_r] <= wr_word_s;
                beat_cnt_r           <= beat_cnt_r + 2'd1;
            end
            if (del_s) begin
                obj_map_r[wr_obj] <= 1'b0;
            end else if (commit_s) begin
                obj_map_r[obj_r] <= 1'b1;
            end
            // A set in the same cycle as clr_changed must win.
            if (del_s || commit_s) begin
                changed_r <= 1'b1;
            end else if (clr_changed) begin
                changed_r <= 1'b0;
            end
        end
    end

    // Point RAM: whole object copied from the shadow in one cycle; not reset.
    always_ff @(posedge clk) begin
        if (commit_s) begin
            mem_r[obj_r][2'd0] <= shadow_r[2'd0];
            mem_r[obj_r][2'd1] <= shadow_r[2'd1];
            mem_r[obj_r][2'd2] <= shadow_r[2'd2];
            mem_r[obj_r][2'd3] <= shadow_r[2'd3];
        end
    end

    assign rd_sel_s  = onehot2idx(rd_cycle);
    assign rd_word_s = mem_r[rd_addr][rd_sel_s[1:0]];
    assign rd_ok_s   = rd_en & obj_map_r[rd_addr] & rd_sel_s[2] & ~writing_r;

    // Registered read port; data holds while no valid read is issued.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_pt_r     <= '0;
            rd_pt_vld_r <= 1'b0;
`ifdef CLIP_STORE_PARITY_EN
            rd_par_r    <= 1'b0;
            par_err_r   <= 1'b0;
`endif
        end else begin
            rd_pt_vld_r <= rd_ok_s;
            if (rd_ok_s) begin
                rd_pt_r <= rd_word_s[PT_W-1:0];
`ifdef CLIP_STORE_PARITY_EN
                rd_par_r <= rd_word_s[PT_W];
`endif
            end
`ifdef CLIP_STORE_PARITY_EN
            if (rd_pt_vld_r && (even_par(rd_pt_r) != rd_par_r)) begin
                par_err_r <= 1'b1;
            end
`endif
        end
    end

endmodule

// File: tb/tb_clip_obj_store.sv
// Directed plus randomized bench for clip_obj_store, checked against a transaction-level model of the store.
module tb_clip_obj_store;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wr_req, wr_del, wr_vld;
    logic [4:0]  wr_obj;
    logic [47:0] wr_pt;
    logic        wr_rdy, wr_done;
    logic        rd_en;
    logic [4:0]  rd_addr;
    logic [3:0]  rd_cycle;
    logic        clr_changed;
    logic [47:0] rd_pt;
    logic        rd_pt_vld;
    logic [31:0] obj_map;
    logic        changed, writing;
`ifdef CLIP_STORE_PARITY_EN
    logic        par_err;
`endif

    int checks   = 0;
    int failures = 0;

    logic [47:0] m_mem [32][4];
    bit          m_valid [32];
    bit          m_changed;
    logic [47:0] exp_rd_pt;

    clip_obj_store dut (
        .clk(clk), .rst_n(rst_n),
        .wr_req(wr_req), .wr_del(wr_del), .wr_obj(wr_obj),
        .wr_vld(wr_vld), .wr_pt(wr_pt), .wr_rdy(wr_rdy), .wr_done(wr_done),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_cycle(rd_cycle),
        .clr_changed(clr_changed), .rd_pt(rd_pt), .rd_pt_vld(rd_pt_vld),
        .obj_map(obj_map), .changed(changed),
`ifdef CLIP_STORE_PARITY_EN
        .writing(writing), .par_err(par_err)
`else
        .writing(writing)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: observed no end of test, expected $finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_map();
        logic [31:0] r;
        for (int i = 0; i < 32; i++) r[i] = m_valid[i];
        return r;
    endfunction

    function automatic logic [47:0] rand_pt();
        return {16'($urandom()), 32'($urandom())};
    endfunction

    task automatic do_write(input int obj, input logic [15:0] pat, input bit clr_at_commit, input bit rd_during);
        logic [47:0] pts [4];
        int n;
        int i;
        bit v;
        for (int k = 0; k < 4; k++) pts[k] = rand_pt();
        chk("wr_rdy_idle", 64'(wr_rdy), 64'(1'b1));
        wr_req = 1'b1; wr_del = 1'b0; wr_obj = 5'(obj);
        @(negedge clk);
        wr_req = 1'b0;
        chk("writing_beat", 64'(writing), 64'(1'b1));
        if (rd_during) begin
            rd_en = 1'b1; rd_addr = 5'(obj); rd_cycle = 4'b0001;
        end
        n = 0; i = 0;
        while (n < 4) begin
            v = (i < 16) ? pat[i] : 1'b1;
            wr_vld = v;
            wr_pt  = v ? pts[n] : rand_pt();
            @(negedge clk);
            if (v) n++;
            i++;
            if (rd_during) begin
                chk("rd_vld_in_beat", 64'(rd_pt_vld), 64'(1'b0));
                chk("rd_pt_held_beat", 64'(rd_pt), 64'(exp_rd_pt));
            end
            if (n < 4) chk("wr_rdy_beat", 64'(wr_rdy), 64'(1'b1));
        end
        wr_vld = 1'b0;
        chk("wr_rdy_commit", 64'(wr_rdy), 64'(1'b0));
        chk("wr_done_early", 64'(wr_done), 64'(1'b0));
        chk("writing_commit", 64'(writing), 64'(1'b1));
        if (clr_at_commit) clr_changed = 1'b1;
        @(negedge clk);
        clr_changed = 1'b0;
        if (rd_during) begin
            chk("rd_vld_commit", 64'(rd_pt_vld), 64'(1'b0));
            chk("rd_pt_held_commit", 64'(rd_pt), 64'(exp_rd_pt));
        end
        rd_en = 1'b0;
        for (int k = 0; k < 4; k++) m_mem[obj][k] = pts[k];
        m_valid[obj] = 1'b1;
        m_changed    = 1'b1;
        chk("wr_done_pulse", 64'(wr_done), 64'(1'b1));
        chk("obj_map_commit", 64'(obj_map), 64'(model_map()));
        chk("changed_commit", 64'(changed), 64'(m_changed));
        chk("writing_after", 64'(writing), 64'(1'b0));
        @(negedge clk);
        chk("wr_done_end", 64'(wr_done), 64'(1'b0));
        chk("wr_rdy_back", 64'(wr_rdy), 64'(1'b1));
    endtask

    task automatic do_delete(input int obj);
        wr_req = 1'b1; wr_del = 1'b1; wr_obj = 5'(obj);
        @(negedge clk);
        wr_req = 1'b0; wr_del = 1'b0;
        m_valid[obj] = 1'b0;
        m_changed    = 1'b1;
        chk("del_wr_done", 64'(wr_done), 64'(1'b1));
        chk("del_writing", 64'(writing), 64'(1'b1));
        chk("del_obj_map", 64'(obj_map), 64'(model_map()));
        chk("del_changed", 64'(changed), 64'(m_changed));
        @(negedge clk);
        chk("del_writing_end", 64'(writing), 64'(1'b0));
        chk("del_wr_done_end", 64'(wr_done), 64'(1'b0));
    endtask

    task automatic do_read(input bit en, input int addr, input logic [3:0] cyc);
        bit exp_v;
        int idx;
        rd_en = en; rd_addr = 5'(addr); rd_cycle = cyc;
        @(negedge clk);
        idx = 0;
        for (int k = 0; k < 4; k++) if (cyc[k]) idx = k;
        exp_v = en && m_valid[addr] && ($countones(cyc) == 1);
        if (exp_v) exp_rd_pt = m_mem[addr][idx];
        chk("rd_pt_vld", 64'(rd_pt_vld), 64'(exp_v));
        chk("rd_pt", 64'(rd_pt), 64'(exp_rd_pt));
    endtask

    task automatic do_clear();
        clr_changed = 1'b1;
        @(negedge clk);
        clr_changed = 1'b0;
        m_changed = 1'b0;
        chk("changed_cleared", 64'(changed), 64'(m_changed));
    endtask

    initial begin
        rst_n = 1'b0; wr_req = 1'b0; wr_del = 1'b0; wr_obj = 5'd0; wr_vld = 1'b0;
        wr_pt = 48'd0; rd_en = 1'b0; rd_addr = 5'd0; rd_cycle = 4'd0; clr_changed = 1'b0;
        for (int i = 0; i < 32; i++) m_valid[i] = 1'b0;
        m_changed = 1'b0;
        exp_rd_pt = 48'd0;

        // Reset values.
        repeat (3) @(negedge clk);
        chk("rst_wr_rdy", 64'(wr_rdy), 64'(1'b0));
        chk("rst_wr_done", 64'(wr_done), 64'(1'b0));
        chk("rst_obj_map", 64'(obj_map), 64'(32'd0));
        chk("rst_changed", 64'(changed), 64'(1'b0));
        chk("rst_writing", 64'(writing), 64'(1'b0));
        chk("rst_rd_pt_vld", 64'(rd_pt_vld), 64'(1'b0));
        chk("rst_rd_pt", 64'(rd_pt), 64'(48'd0));
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // 1) write obj 3, 2) read its four points in successive cycles.
        do_write(3, 16'hFFFF, 1'b0, 1'b0);
        chk("map_obj3", 64'(obj_map), 64'(32'h8));
        do_read(1'b1, 3, 4'b0001);
        do_read(1'b1, 3, 4'b0010);
        do_read(1'b1, 3, 4'b0100);
        do_read(1'b1, 3, 4'b1000);
        do_read(1'b1, 3, 4'b0011);
        do_read(1'b1, 3, 4'b0000);

        // 3) empty slot read, then delete.
        do_read(1'b1, 5, 4'b0001);
        do_clear();
        do_delete(3);
        chk("map_after_del", 64'(obj_map), 64'(32'h0));

        // 4) commit coinciding with clr_changed: set wins.
        do_clear();
        do_write(7, 16'hFFFF, 1'b1, 1'b0);
        do_clear();
        do_read(1'b1, 7, 4'b0100);

        // 5) gapped beats with reads of the same slot during the transaction.
        do_write(7, 16'b0000_0000_0101_1001, 1'b0, 1'b1);
        do_read(1'b1, 7, 4'b0001);
        do_read(1'b1, 7, 4'b1000);
        do_read(1'b0, 7, 4'b0010);

        // 6) reset in the middle of a transaction.
        wr_req = 1'b1; wr_del = 1'b0; wr_obj = 5'd9;
        @(negedge clk);
        wr_req = 1'b0; wr_vld = 1'b1; wr_pt = rand_pt();
        @(negedge clk);
        wr_pt = rand_pt();
        @(negedge clk);
        wr_vld = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_obj_map", 64'(obj_map), 64'(32'd0));
        chk("mid_rst_writing", 64'(writing), 64'(1'b0));
        chk("mid_rst_wr_done", 64'(wr_done), 64'(1'b0));
        chk("mid_rst_changed", 64'(changed), 64'(1'b0));
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 32; i++) m_valid[i] = 1'b0;
        m_changed = 1'b0;
        exp_rd_pt = 48'd0;
        repeat (2) begin
            @(negedge clk);
            chk("post_rst_wr_done", 64'(wr_done), 64'(1'b0));
            chk("post_rst_writing", 64'(writing), 64'(1'b0));
        end
        chk("post_rst_wr_rdy", 64'(wr_rdy), 64'(1'b1));
        do_read(1'b1, 7, 4'b0001);
        do_read(1'b1, 9, 4'b0001);
        do_write(9, 16'hFFFF, 1'b0, 1'b0);
        do_read(1'b1, 9, 4'b0010);

        // Randomized mix of transactions, reads and clears.
        for (int it = 0; it < 80; it++) begin
            int op;
            op = int'($urandom_range(0, 9));
            if (op <= 2) begin
                do_write(int'($urandom_range(0, 31)), 16'($urandom()), 1'($urandom()), 1'($urandom()));
            end else if (op == 3) begin
                do_delete(int'($urandom_range(0, 31)));
            end else if (op == 4) begin
                do_clear();
            end else begin
                for (int r = 0; r < 4; r++) begin
                    do_read(($urandom_range(0, 7) != 0), int'($urandom_range(0, 31)),
                            ($urandom_range(0, 3) == 0) ? 4'($urandom()) : 4'(4'b0001 << $urandom_range(0, 3)));
                end
            end
        end
        chk("final_obj_map", 64'(obj_map), 64'(model_map()));
        chk("final_changed", 64'(changed), 64'(m_changed));
`ifdef CLIP_STORE_PARITY_EN
        chk("par_err_clean", 64'(par_err), 64'(1'b0));
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
